// File: rtl/ab_mem_server_if.sv
// Load/read/control bundle between the SAD engine, the loader and ab_mem_server.
// rd_err exists only when AB_MEM_ERR_EN is defined.
interface ab_mem_server_if;
    logic       AB_rd;
    logic [8:0] AB_addr;
    logic [7:0] A_data;
    logic [7:0] B_data;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       start;
    logic       reload;
    logic       go;
    logic       loaded;
`ifdef AB_MEM_ERR_EN
    logic       rd_err;
`endif

    modport slave (
        input  AB_rd, AB_addr, wr_valid, wr_data, start, reload,
        output A_data, B_data, wr_ready, go, loaded
`ifdef AB_MEM_ERR_EN
        , output rd_err
`endif
    );

    modport master (
        output AB_rd, AB_addr, wr_valid, wr_data, start, reload,
        input  A_data, B_data, wr_ready, go, loaded
`ifdef AB_MEM_ERR_EN
        , input rd_err
`endif
    );
endinterface

// File: rtl/ab_mem_server.sv
// Two 256x8 block buffers: loaded sequentially (A then B), then read combinationally.
// Optional AB_MEM_ERR_EN adds the sticky rd_err flag.
module ab_mem_server (
    input  logic             clk,
    input  logic             rst,
    ab_mem_server_if.slave   bus
);
    typedef enum logic [1:0] {LOAD_A, LOAD_B, READY} state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_go, w_go_nxt;
    logic       r_loaded;
    logic       w_we_a, w_we_b;
    logic       w_rd_ok;
    logic [7:0] r_mem_a [256];
    logic [7:0] r_mem_b [256];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LOAD_A;
            r_cnt    <= 8'd0;
            r_go     <= 1'b0;
            r_loaded <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_go     <= w_go_nxt;
            r_loaded <= (w_state_nxt == READY);
        end
    end

    // reload takes priority over any write or start in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_go_nxt    = 1'b0;
        w_we_a      = 1'b0;
        w_we_b      = 1'b0;
        if (bus.reload) begin
            w_state_nxt = LOAD_A;
            w_cnt_nxt   = 8'd0;
        end else begin
            case (r_state)
                LOAD_A: if (bus.wr_valid) begin
                    w_we_a    = 1'b1;
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (r_cnt == 8'hFF) w_state_nxt = LOAD_B;
                end
                LOAD_B: if (bus.wr_valid) begin
                    w_we_b    = 1'b1;
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (r_cnt == 8'hFF) w_state_nxt = READY;
                end
                READY:   w_go_nxt = bus.start && !r_go;
                default: w_state_nxt = LOAD_A;
            endcase
        end
    end

    // Storage is deliberately not reset; a reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && w_we_a) r_mem_a[r_cnt] <= bus.wr_data;
        if (!rst && w_we_b) r_mem_b[r_cnt] <= bus.wr_data;
    end

    assign w_rd_ok     = (r_state == READY) && bus.AB_rd && !bus.AB_addr[8];
    assign bus.A_data  = w_rd_ok ? r_mem_a[bus.AB_addr[7:0]] : 8'd0;
    assign bus.B_data  = w_rd_ok ? r_mem_b[bus.AB_addr[7:0]] : 8'd0;
    assign bus.wr_ready = (r_state != READY);
    assign bus.go      = r_go;
    assign bus.loaded  = r_loaded;

`ifdef AB_MEM_ERR_EN
    logic r_rd_err;
    always_ff @(posedge clk) begin
        if (rst || bus.reload)
            r_rd_err <= 1'b0;
        else if (bus.AB_rd && (bus.AB_addr[8] || r_state != READY))
            r_rd_err <= 1'b1;
    end
    assign bus.rd_err = r_rd_err;
`endif
endmodule
